// File: rtl/shift_issue_stage.sv
// ID/EX register and operand select for RV32I shifts.
// Applies EX/MEM and MEM/WB bypass to the registered rs1/rs2 values.
module shift_issue_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [2:0]  id_funct3,
    input  logic        id_funct7_5,
    input  logic        id_is_imm,
    input  logic [4:0]  id_shamt,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [4:0]  id_rd,
    input  logic        exm_we,
    input  logic [4:0]  exm_rd,
    input  logic [31:0] exm_data,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        ex_valid,
    output logic [4:0]  ex_rd,
    output logic        ex_illegal,
    output logic [31:0] data,
    output logic [4:0]  sa,
    output logic        right,
    output logic        arith,
    output logic [31:0] shift_count
);

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [4:0]  rd;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic        is_imm;
        logic [4:0]  shamt;
        logic        right;
        logic        arith;
    } ex_t;

    ex_t         ex_q, ex_d, ld;
    logic [31:0] cnt_q, cnt_d;
    logic        legal;
    logic [31:0] rs1_fwd, rs2_fwd;
    logic        unused_rs2;

    function automatic logic [31:0] fwd(input logic [4:0] a,
                                        input logic [31:0] d);
        if (FWD_EN && exm_we && exm_rd == a && a != 5'd0)
            return exm_data;
        else if (FWD_EN && wb_we && wb_rd == a && a != 5'd0)
            return wb_data;
        else
            return d;
    endfunction

    always_comb begin
        legal = (id_funct3 == 3'b101) ||
                (id_funct3 == 3'b001 && !id_funct7_5);
        ld = '0;
        if (legal) begin
            ld.valid    = id_valid;
            ld.rd       = id_rd;
            ld.rs1_addr = id_rs1_addr;
            ld.rs2_addr = id_rs2_addr;
            ld.rs1_data = id_rs1_data;
            ld.rs2_data = id_rs2_data;
            ld.is_imm   = id_is_imm;
            ld.shamt    = id_shamt;
            ld.right    = id_funct3[2];
            ld.arith    = id_funct3[2] & id_funct7_5;
        end else begin
            ld.illegal  = id_valid;
        end
    end

    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (flush) begin
            ex_d = '0;
        end else if (!stall) begin
            ex_d = ld;
            if (legal && id_valid)
                cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    // Bypass is re-evaluated every cycle so a stalled op sees late producers.
    always_comb begin
        rs1_fwd = fwd(ex_q.rs1_addr, ex_q.rs1_data);
        rs2_fwd = fwd(ex_q.rs2_addr, ex_q.rs2_data);
    end

    assign unused_rs2  = ^rs2_fwd[31:5];
    assign data        = rs1_fwd;
    assign sa          = ex_q.is_imm ? ex_q.shamt : rs2_fwd[4:0];
    assign right       = ex_q.right;
    assign arith       = ex_q.arith;
    assign ex_valid    = ex_q.valid;
    assign ex_illegal  = ex_q.illegal;
    assign ex_rd       = ex_q.rd;
    assign shift_count = cnt_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage, with a second instance
// built without forwarding.
module tb_shift_issue_stage;

    logic        clk;
    logic        rst_n, stall, flush;
    logic        id_valid, id_funct7_5, id_is_imm;
    logic [2:0]  id_funct3;
    logic [4:0]  id_shamt, id_rs1_addr, id_rs2_addr, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data;
    logic        exm_we, wb_we;
    logic [4:0]  exm_rd, wb_rd;
    logic [31:0] exm_data, wb_data;

    logic        ex_valid, ex_illegal, right, arith;
    logic [4:0]  ex_rd, sa;
    logic [31:0] data, shift_count;

    logic        n_valid, n_illegal, n_right, n_arith;
    logic [4:0]  n_rd, n_sa;
    logic [31:0] n_data, n_count;

    int n_chk = 0;
    int n_fail = 0;

    shift_issue_stage #(.FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_funct3(id_funct3),
        .id_funct7_5(id_funct7_5), .id_is_imm(id_is_imm),
        .id_shamt(id_shamt), .id_rs1_addr(id_rs1_addr),
        .id_rs2_addr(id_rs2_addr), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_rd(id_rd),
        .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_illegal(ex_illegal),
        .data(data), .sa(sa), .right(right), .arith(arith),
        .shift_count(shift_count)
    );

    shift_issue_stage #(.FWD_EN(1'b0)) dut_nf (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_funct3(id_funct3),
        .id_funct7_5(id_funct7_5), .id_is_imm(id_is_imm),
        .id_shamt(id_shamt), .id_rs1_addr(id_rs1_addr),
        .id_rs2_addr(id_rs2_addr), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_rd(id_rd),
        .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(n_valid), .ex_rd(n_rd), .ex_illegal(n_illegal),
        .data(n_data), .sa(n_sa), .right(n_right), .arith(n_arith),
        .shift_count(n_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_id(input logic v, input logic [2:0] f3,
                          input logic f75, input logic imm,
                          input logic [4:0] sh, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [4:0] rd);
        id_valid = v; id_funct3 = f3; id_funct7_5 = f75;
        id_is_imm = imm; id_shamt = sh;
        id_rs1_addr = a1; id_rs2_addr = a2;
        id_rs1_data = d1; id_rs2_data = d2; id_rd = rd;
    endtask

    task automatic bypass_off();
        exm_we = 0; exm_rd = 0; exm_data = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0; stall = 0; flush = 0;
        bypass_off();
        set_id(1, 3'b101, 1, 1, 5'd9, 5'd1, 5'd2, 32'hDEAD, 32'h3, 5'd6);
        tick(); tick();
        n_chk++;
        if ({ex_valid, ex_illegal, ex_rd, right, arith, sa} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_ctl: got v%b i%b rd%0d r%b a%b sa%0d want 0",
                     ex_valid, ex_illegal, ex_rd, right, arith, sa);
        end
        n_chk++;
        if (data !== 32'd0 || shift_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got data=%h cnt=%h want 0/0",
                     data, shift_count);
        end
    endtask

    task automatic test_srai();
        @(negedge clk);
        rst_n = 1;
        set_id(1, 3'b101, 1, 1, 5'd16, 5'd1, 5'd2,
               32'h8000_0001, 32'h0, 5'd3);
        tick();
        n_chk++;
        if (data !== 32'h8000_0001 || sa !== 5'd16) begin
            n_fail++;
            $display("FAIL srai_op: got data=%h sa=%0d want 80000001/16",
                     data, sa);
        end
        n_chk++;
        if ({ex_valid, right, arith} !== 3'b111 || ex_rd !== 5'd3) begin
            n_fail++;
            $display("FAIL srai_ctl: got v%b r%b a%b rd%0d want 1 1 1 3",
                     ex_valid, right, arith, ex_rd);
        end
        n_chk++;
        if (shift_count !== 32'd1) begin
            n_fail++;
            $display("FAIL srai_cnt: got %0d want 1", shift_count);
        end
    endtask

    task automatic test_srl_reg();
        @(negedge clk);
        set_id(1, 3'b101, 0, 0, 5'd31, 5'd1, 5'd2,
               32'h1234_5678, 32'h0000_0024, 5'd8);
        tick();
        n_chk++;
        if (sa !== 5'd4 || {right, arith} !== 2'b10) begin
            n_fail++;
            $display("FAIL srl_reg: got sa=%0d r%b a%b want 4 1 0",
                     sa, right, arith);
        end
        n_chk++;
        if (data !== 32'h1234_5678 || shift_count !== 32'd2) begin
            n_fail++;
            $display("FAIL srl_data: got data=%h cnt=%0d want 12345678/2",
                     data, shift_count);
        end
    endtask

    task automatic test_forward();
        @(negedge clk);
        set_id(1, 3'b001, 0, 0, 5'd0, 5'd5, 5'd5,
               32'h55, 32'h2, 5'd10);
        tick();
        n_chk++;
        if (data !== 32'h55 || sa !== 5'd2 || right !== 1'b0) begin
            n_fail++;
            $display("FAIL sll_nofwd: got data=%h sa=%0d r%b want 55/2/0",
                     data, sa, right);
        end
        exm_we = 1; exm_rd = 5; exm_data = 32'hF000_0000;
        wb_we = 1; wb_rd = 5; wb_data = 32'h1;
        #1;
        n_chk++;
        if (data !== 32'hF000_0000 || sa !== 5'd0) begin
            n_fail++;
            $display("FAIL fwd_prio: got data=%h sa=%0d want f0000000/0",
                     data, sa);
        end
        n_chk++;
        if (n_data !== 32'h55 || n_sa !== 5'd2) begin
            n_fail++;
            $display("FAIL fwd_disabled: got data=%h sa=%0d want 55/2",
                     n_data, n_sa);
        end
        exm_we = 0;
        #1;
        n_chk++;
        if (data !== 32'h1 || sa !== 5'd1) begin
            n_fail++;
            $display("FAIL fwd_wb: got data=%h sa=%0d want 1/1", data, sa);
        end
        @(negedge clk);
        bypass_off();
        set_id(1, 3'b001, 0, 1, 5'd3, 5'd0, 5'd0, 32'h0, 32'h0, 5'd11);
        tick();
        exm_we = 1; exm_rd = 0; exm_data = 32'hABCD;
        wb_we = 1; wb_rd = 0; wb_data = 32'h1234;
        #1;
        n_chk++;
        if (data !== 32'h0 || sa !== 5'd3 || shift_count !== 32'd4) begin
            n_fail++;
            $display("FAIL fwd_x0: got data=%h sa=%0d cnt=%0d want 0/3/4",
                     data, sa, shift_count);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        bypass_off();
        set_id(1, 3'b001, 0, 1, 5'd7, 5'd9, 5'd0, 32'h1234, 32'h0, 5'd4);
        tick();
        n_chk++;
        if (ex_rd !== 5'd4 || sa !== 5'd7 || shift_count !== 32'd5) begin
            n_fail++;
            $display("FAIL slli_load: got rd=%0d sa=%0d cnt=%0d want 4/7/5",
                     ex_rd, sa, shift_count);
        end
        @(negedge clk);
        stall = 1;
        set_id(1, 3'b101, 1, 1, 5'd1, 5'd2, 5'd3, 32'h99, 32'h0, 5'd7);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++;
            if (ex_rd !== 5'd4 || sa !== 5'd7 || ex_valid !== 1'b1 ||
                {right, arith} !== 2'b00 || shift_count !== 32'd5) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got rd=%0d sa=%0d v%b r%b a%b cnt=%0d want 4/7/1/0/0/5",
                         k, ex_rd, sa, ex_valid, right, arith, shift_count);
            end
            n_chk++;
            if (data !== (k == 0 ? 32'h1234 : 32'hFFFF)) begin
                n_fail++;
                $display("FAIL stall_data%0d: got %h want %h", k, data,
                         (k == 0 ? 32'h1234 : 32'hFFFF));
            end
            if (k == 0) begin
                exm_we = 1; exm_rd = 9; exm_data = 32'hFFFF;
            end
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        bypass_off();
        stall = 1; flush = 1;
        set_id(1, 3'b101, 0, 1, 5'd5, 5'd1, 5'd2, 32'h77, 32'h0, 5'd12);
        tick();
        n_chk++;
        if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_illegal !== 1'b0 ||
            shift_count !== 32'd5) begin
            n_fail++;
            $display("FAIL flush_prio: got v%b rd%0d i%b cnt=%0d want 0/0/0/5",
                     ex_valid, ex_rd, ex_illegal, shift_count);
        end
        n_chk++;
        if (data !== 32'd0 || sa !== 5'd0 || right !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_data: got data=%h sa=%0d r%b want 0",
                     data, sa, right);
        end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        stall = 0; flush = 0;
        set_id(1, 3'b001, 1, 1, 5'd2, 5'd1, 5'd0, 32'h5, 32'h0, 5'd13);
        tick();
        n_chk++;
        if (ex_illegal !== 1'b1 || ex_valid !== 1'b0 || ex_rd !== 5'd0 ||
            shift_count !== 32'd5) begin
            n_fail++;
            $display("FAIL illegal_f7: got i%b v%b rd%0d cnt=%0d want 1/0/0/5",
                     ex_illegal, ex_valid, ex_rd, shift_count);
        end
        @(negedge clk);
        id_valid = 0; id_funct3 = 3'b101;
        tick();
        n_chk++;
        if (ex_illegal !== 1'b0 || ex_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_len: got i%b v%b want 0/0",
                     ex_illegal, ex_valid);
        end
        @(negedge clk);
        set_id(1, 3'b000, 0, 1, 5'd2, 5'd1, 5'd0, 32'h5, 32'h0, 5'd14);
        tick();
        n_chk++;
        if (ex_illegal !== 1'b1 || ex_valid !== 1'b0 ||
            shift_count !== 32'd5) begin
            n_fail++;
            $display("FAIL illegal_f3: got i%b v%b cnt=%0d want 1/0/5",
                     ex_illegal, ex_valid, shift_count);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFF;
        set_id(1, 3'b001, 0, 1, 5'd1, 5'd1, 5'd0, 32'h1, 32'h0, 5'd15);
        #1;
        release dut.cnt_q;
        tick();
        n_chk++;
        if (shift_count !== 32'd0 || ex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL cnt_wrap: got cnt=%h v%b want 0/1",
                     shift_count, ex_valid);
        end
    endtask

    task automatic test_reset_in_stall();
        @(negedge clk);
        rst_n = 0; stall = 1; flush = 1;
        set_id(1, 3'b101, 1, 1, 5'd8, 5'd1, 5'd0, 32'h42, 32'h0, 5'd16);
        tick();
        n_chk++;
        if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || sa !== 5'd0 ||
            data !== 32'd0 || n_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stall: got v%b rd%0d sa%0d data=%h cnt=%0d want 0",
                     ex_valid, ex_rd, sa, data, n_count);
        end
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0;
        bypass_off();
        set_id(0, 3'b000, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0);
        test_reset();
        test_srai();
        test_srl_reg();
        test_forward();
        test_stall();
        test_flush();
        test_illegal();
        test_wrap();
        test_reset_in_stall();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_issue_stage.md
# shift_issue_stage

ID/EX pipeline register and operand-select stage for RV32I shift instructions (SLL, SRL, SRA, SLLI, SRLI, SRAI). It captures decoded shift ops from ID and applies EX/MEM and MEM/WB forwarding to rs1 and rs2. It then drives the combinational `shifter` in EX with `data`, `sa`, `right` and `arith`. It also handles pipeline stall and flush, flags illegal shift encodings, and counts issued shifts.

## Interface
Parameters:
- `FWD_EN`, default 1: 1 enables forwarding; 0 makes operands always the registered ID values.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous active-low reset
- `stall`  in  1  hold the current EX contents
- `flush`  in  1  load a bubble; takes priority over `stall`
- `id_valid`  in  1  the ID slot holds a shift-class instruction
- `id_funct3`  in  3  001 = SLL(I), 101 = SRL/SRA(I)
- `id_funct7_5`  in  1  instruction bit 30
- `id_is_imm`  in  1  1 = immediate form (shamt), 0 = register form (rs2)
- `id_shamt`  in  5  immediate shift amount
- `id_rs1_addr`, `id_rs2_addr`  in  5 each  source register indices
- `id_rs1_data`, `id_rs2_data`  in  32 each  register-file read data
- `id_rd`  in  5  destination register
- `exm_we`  in  1, `exm_rd`  in  5, `exm_data`  in  32: EX/MEM writeback candidate
- `wb_we`  in  1, `wb_rd`  in  5, `wb_data`  in  32: MEM/WB writeback candidate
- `ex_valid`  out  1  the EX slot holds a legal shift
- `ex_rd`  out  5  destination register of the EX slot
- `ex_illegal`  out  1  the EX slot holds an illegal shift encoding
- `data`  out  32  shifter operand
- `sa`  out  5  shift amount
- `right`  out  1  1 = right shift
- `arith`  out  1  1 = arithmetic shift
- `shift_count`  out  32  number of legal shifts issued; wraps modulo 2^32

## Operation
- **Capture.** On each rising edge, the next register state is chosen in this priority order:
  - if `!rst_n`: reset;
  - else if `flush`: bubble;
  - else if `stall`: hold;
  - else: load from ID.
- **Legality.** An encoding is legal if `funct3` == 101, or if `funct3` == 001 with `funct7_5` == 0. Every other `funct3` value, and `funct3` == 001 with `funct7_5` == 1, is illegal.
- **Load of a legal op.** Registered `ex_valid` = `id_valid`, `ex_illegal` = 0. Store the rs1/rs2 addresses and data, `is_imm`, `shamt`, `rd`, `right` = `funct3[2]`, and `arith` = `funct3[2] & funct7_5`.
- **Load of an illegal op** (when `id_valid` = 1): `ex_valid` = 0, `ex_illegal` = 1, `ex_rd` = 0.
- **Bubble:** `ex_valid` = 0, `ex_illegal` = 0, `ex_rd` = 0, every data field = 0.
- **Forwarding.** This path is combinational, computed from the registered addresses and the current bypass inputs. It is evaluated every cycle, including stalled cycles, so a producer arriving while stalled is picked up.
  - For each source register: if `FWD_EN` and `exm_we` and `exm_rd` == addr and addr != 0, use `exm_data`.
  - Else if `FWD_EN` and `wb_we` and `wb_rd` == addr and addr != 0, use `wb_data`.
  - Else use the registered read data.
  - EX/MEM wins over MEM/WB. Register x0 is never forwarded.
- **Output derivation:**
  - `data` = forwarded rs1.
  - `sa` = registered `shamt` if `is_imm`, else forwarded rs2[4:0]. The upper 27 bits of rs2 are ignored.
  - `right` and `arith` come straight from the registers.
- **Counter.** `shift_count` increments by 1 on an edge where a legal op with `id_valid` = 1 is loaded (no reset, no flush, no stall). It holds otherwise and wraps from 0xFFFFFFFF to 0.

## Timing
- Latency: an ID instruction presented in cycle N appears on the outputs in cycle N+1.
- Forwarding mux, `data` and `sa` are combinational from the registered state; no extra cycle.
- Reset values: `ex_valid` = 0, `ex_illegal` = 0, `ex_rd` = 0, `right` = 0, `arith` = 0, `sa` = 0, `data` = 0 (registered rs1 = 0, addr = 0), `shift_count` = 0.
- Reset asserted mid-stall or mid-flush overrides both on that edge.
- `stall` held for K cycles: outputs, apart from forwarded values, are held for K cycles. `shift_count` does not change during the stall.
- `flush` and `stall` in the same cycle: a bubble is loaded.
- `ex_illegal` lasts exactly one cycle unless it is held by `stall`.

## Test plan
- Reset, then SRAI: `rst_n` = 0 for 2 cycles gives all outputs 0. Then SRAI with rs1 data 0x80000001 and shamt 16 gives, next cycle, `data` = 0x80000001, `sa` = 16, `right` = 1, `arith` = 1, `ex_valid` = 1, `shift_count` = 1.
- SRL register form: rs2 data = 0x00000024 and rs1 data = 0x12345678 give `sa` = 4, `right` = 1, `arith` = 0.
- Forwarding priority: rs1 = x5; `exm_we`=1, `exm_rd`=5, `exm_data`=0xF0000000; `wb_we`=1, `wb_rd`=5, `wb_data`=0x1 gives `data` = 0xF0000000. With the same setup but rs1 = x0, `data` = the registered value 0. With `FWD_EN` = 0, `data` = the registered value.
- Stall with late producer: SLLI is issued and `stall` held for 3 cycles. Outputs stay constant except `data`, which follows `exm_data` = 0xFFFF once `exm_rd` matches. `shift_count` stays unchanged.
- Flush priority: `flush` = 1 and `stall` = 1 with a valid ID op give `ex_valid` = 0, `ex_rd` = 0, and `shift_count` unchanged.
- Illegal encoding: `funct3` = 001 with `funct7_5` = 1 gives `ex_illegal` = 1 and `ex_valid` = 0 for one cycle, with `shift_count` unchanged. Counter wrap: preload to 0xFFFFFFFF via 2^32-1 issues, or a force, then one legal shift gives `shift_count` = 0.
